// File: rtl/if_id_stage.sv
// if_id_stage: instruction-fetch PC plus IF/ID pipeline register.
// Supports hazard stall, bubble flush and EX-stage branch/jump redirect.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [6:0]  funct7,
    output logic [4:0]  rs2,
    output logic [4:0]  rs1,
    output logic [2:0]  funct3,
    output logic [4:0]  rd,
    output logic [6:0]  opcode,
    output logic [31:0] PC_n,
    output logic        valid,
    output logic [31:0] fetch_count
);
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pcn_q, pcn_d, fc_q, fc_d;
    logic        valid_q, valid_d;
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcn_d   = pcn_q;
        valid_d = valid_q;
        fc_d    = fc_q;
        if (redirect || flush) begin
            pc_d    = redirect ? {redirect_pc[31:2], 2'b00} : pc_q + 32'd4;
            instr_d = NOP_INSTR;
            pcn_d   = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pc_q + 32'd4;
            instr_d = imem_rdata;
            pcn_d   = pc_q;
            valid_d = 1'b1;
            fc_d    = fc_q + 32'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcn_q   <= '0;
            valid_q <= 1'b0;
            fc_q    <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcn_q   <= pcn_d;
            valid_q <= valid_d;
            fc_q    <= fc_d;
        end
    end
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign funct7      = instr_q[31:25];
    assign rs2         = instr_q[24:20];
    assign rs1         = instr_q[19:15];
    assign funct3      = instr_q[14:12];
    assign rd          = instr_q[11:7];
    assign opcode      = instr_q[6:0];
    assign PC_n        = pcn_q;
    assign valid       = valid_q;
    assign fetch_count = fc_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: random + directed stimulus, reference model feeds a queue
// that a free-running monitor drains and compares after every clock edge.
module tb_if_id_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, PC_n, fetch_count;
    logic [6:0]  funct7, opcode;
    logic [4:0]  rs2, rs1, rd;
    logic [2:0]  funct3;
    logic        valid;

    if_id_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .funct7(funct7), .rs2(rs2), .rs1(rs1), .funct3(funct3),
        .rd(rd), .opcode(opcode), .PC_n(PC_n), .valid(valid), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0020_8133;
            32'h8:   return 32'h4011_0233;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    always_comb imem_rdata = mem(imem_addr);

    typedef struct {
        logic [31:0] addr, instr, pcn, fc;
        logic        v;
        int          tag;
    } exp_t;
    exp_t q[$];

    logic [31:0] m_pc, m_instr, m_pcn, m_fc;
    logic        m_v;
    int          vectors = 0;
    int          miscompares = 0;

    // Reference: apply one edge of the fetch-stage rules, then queue the result.
    task automatic drive(input logic r, input logic st, input logic fl, input logic rdir,
                         input logic [31:0] rpc, input int tag);
        reset = r; stall = st; flush = fl; redirect = rdir; redirect_pc = rpc;
        if (r) begin
            m_pc = RESET_PC; m_instr = NOP; m_pcn = 0; m_v = 0; m_fc = 0;
        end else if (rdir) begin
            m_pc = rpc & ~32'd3; m_instr = NOP; m_pcn = 0; m_v = 0;
        end else if (fl) begin
            m_pc = m_pc + 4; m_instr = NOP; m_pcn = 0; m_v = 0;
        end else if (!st) begin
            m_instr = mem(m_pc); m_pcn = m_pc; m_v = 1; m_pc = m_pc + 4; m_fc = m_fc + 1;
        end
        q.push_back('{m_pc, m_instr, m_pcn, m_fc, m_v, tag});
        vectors++;
        @(negedge clk);
    endtask

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL queue: got 0 expected entries at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("instr", instr, e.instr);
                chk("funct7", {25'd0, funct7}, {25'd0, e.instr[31:25]});
                chk("rs2", {27'd0, rs2}, {27'd0, e.instr[24:20]});
                chk("rs1", {27'd0, rs1}, {27'd0, e.instr[19:15]});
                chk("funct3", {29'd0, funct3}, {29'd0, e.instr[14:12]});
                chk("rd", {27'd0, rd}, {27'd0, e.instr[11:7]});
                chk("opcode", {25'd0, opcode}, {25'd0, e.instr[6:0]});
                chk("PC_n", PC_n, e.pcn);
                chk("valid", {31'd0, valid}, {31'd0, e.v});
                chk("fetch_count", fetch_count, e.fc);
                if (e.tag == 1) begin
                    chk("t1_funct7", {25'd0, funct7}, 32'h20);
                    chk("t1_rs2", {27'd0, rs2}, 32'd1);
                    chk("t1_rs1", {27'd0, rs1}, 32'd2);
                    chk("t1_funct3", {29'd0, funct3}, 32'd0);
                    chk("t1_rd", {27'd0, rd}, 32'd4);
                    chk("t1_opcode", {25'd0, opcode}, 32'h33);
                    chk("t1_PC_n", PC_n, 32'd8);
                    chk("t1_fetch_count", fetch_count, 32'd3);
                end
                if (e.tag == 2) begin
                    chk("t2_imem_addr", imem_addr, 32'h100);
                    chk("t2_valid", {31'd0, valid}, 32'd0);
                    chk("t2_instr", instr, NOP);
                end
                if (e.tag == 3) begin
                    chk("t3_valid", {31'd0, valid}, 32'd0);
                    chk("t3_opcode", {25'd0, opcode}, 32'h13);
                end
                if (e.tag == 4) begin
                    chk("t4_imem_addr", imem_addr, 32'd0);
                    chk("t4_PC_n", PC_n, 32'hFFFF_FFFC);
                end
                if (e.tag == 5) begin
                    chk("t5_imem_addr", imem_addr, RESET_PC);
                    chk("t5_instr", instr, NOP);
                    chk("t5_PC_n", PC_n, 32'd0);
                    chk("t5_valid", {31'd0, valid}, 32'd0);
                    chk("t5_fetch_count", fetch_count, 32'd0);
                end
                if (e.tag == 7) begin
                    chk("t7_PC_n", PC_n, 32'h100);
                    chk("t7_valid", {31'd0, valid}, 32'd1);
                end
            end
        end
    end

    initial begin
        m_pc = 0; m_instr = NOP; m_pcn = 0; m_v = 0; m_fc = 0;
        drive(1, 0, 0, 0, 0, 5);
        drive(1, 0, 0, 0, 0, 5);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 32'h0000_0103, 2);
        drive(0, 0, 0, 0, 0, 7);
        drive(0, 0, 1, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        drive(0, 0, 0, 0, 0, 4);
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h0000_0040, 5);
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
                  $urandom_range(9) == 0, $urandom, 0);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d expected 0 pending entries", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
